mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high, sampled on posedge clk.
- inst  in  32  current instruction, taken from the instruction register output.
- zero  in  1  ALU zero flag; meaningful in BRANCH only.
- IRWr  out  1  instruction register write enable.
- PCWr  out  1  PC write enable.
- NPCOp  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
- RFWr  out  1  register file write enable.
- DMWr  out  1  data memory write enable.
- ALUOp  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- ALUSrcB  out  1  ALU operand B select: 0 rt register, 1 extended immediate.
- ExtOp  out  1  immediate extension: 1 sign-extend, 0 zero-extend.
- RegDst  out  1  destination register select: 1 rd, 0 rt.
- MemToReg  out  1  write-back data select: 1 memory data, 0 ALU result.
- illegal  out  1  sticky flag: an unsupported instruction was decoded.
- state_o  out  4  current state encoding, for debug and verification.

Function
REQ-002 The block SHALL be a multi-cycle FSM with states FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
REQ-003 FETCH SHALL assert IRWr=1, PCWr=1, NPCOp=00, and always go to DECODE.
REQ-004 In DECODE, inst already holds the value written at the end of FETCH; the next state SHALL be chosen from opcode inst[31:26] and funct inst[5:0].
REQ-005 DECODE transitions and instruction latencies:
- R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a -> EXEC_R -> WB_ALU (4 cycles).
- ori 0x0D -> EXEC_I -> WB_ALU (4 cycles).
- lw 0x23 -> MEM_ADDR -> MEM_RD -> MEM_WB (5 cycles).
- sw 0x2B -> MEM_ADDR -> MEM_WR (4 cycles).
- beq 0x04 -> BRANCH (3 cycles).
- j 0x02 -> JUMP (3 cycles).
REQ-006 The final state of every instruction SHALL return to FETCH.
REQ-007 Any other opcode, or an R-type with an unlisted funct, SHALL go DECODE -> FETCH and set illegal=1 on the same edge; illegal stays 1 until reset.
REQ-008 Per-state controls:
- EXEC_R: ALUOp from funct, ALUSrcB=0.
- EXEC_I: ALUOp=011, ALUSrcB=1, ExtOp=0.
- WB_ALU: RFWr=1, MemToReg=0, RegDst=1 if the instruction is R-type, else 0.
- MEM_ADDR: ALUOp=000, ALUSrcB=1, ExtOp=1.
- MEM_RD: no enables asserted.
- MEM_WB: RFWr=1, MemToReg=1, RegDst=0.
- MEM_WR: DMWr=1.
- BRANCH: ALUOp=001, ALUSrcB=0, NPCOp=01, PCWr=zero.
- JUMP: PCWr=1, NPCOp=10.
REQ-009 Every output not listed for a state SHALL be 0 in that state.
REQ-010 All outputs except PCWr in BRANCH SHALL be Moore (a function of the registered state and inst only); PCWr in BRANCH SHALL follow zero combinationally in the same cycle.
REQ-011 At most one of IRWr, RFWr and DMWr SHALL be 1 in any cycle.
REQ-012 The FSM SHALL have no stall or wait states; each state lasts exactly one cycle.

Reset
REQ-013 While rst=1 at a posedge, the next state SHALL be FETCH and illegal SHALL be cleared.
REQ-014 While rst=1, all enables (IRWr, PCWr, RFWr, DMWr) SHALL be forced to 0 combinationally.
REQ-015 Reset asserted mid-instruction SHALL abandon that instruction with no further RFWr, DMWr or PCWr.
REQ-016 In the first cycle after rst falls, the state SHALL be FETCH with IRWr=1.
REQ-017 Unused state encodings SHALL transition to FETCH.

Structure
REQ-018 A shared package mc_pkg SHALL hold:
- the state enum (4 bits),
- opcode and funct constants,
- the ALUOp and NPCOp encodings.
REQ-019 A combinational sub-module mc_decode SHALL map opcode and funct to an instruction class (RTYPE, ORI, LW, SW, BEQ, J, ILL) plus the R-type ALUOp.
REQ-020 mc_ctrl SHALL instantiate mc_decode and hold only the state register, the illegal flag and the output logic.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Release rst, then inst=0x00221820 (add $3,$1,$2) -> states FETCH, DECODE, EXEC_R, WB_ALU, FETCH; RFWr=1 with RegDst=1 only in cycle 4; ALUOp=000 in cycle 3.
- inst=0x8C220004 (lw) -> 5-cycle sequence; RFWr=1 with MemToReg=1 only in MEM_WB; DMWr=0 throughout.
- inst=0x10220001 (beq) run twice, with zero=1 then zero=0 in BRANCH -> PCWr=1 with NPCOp=01, then PCWr=0; both runs return to FETCH after 3 cycles.
- inst=0x08000010 (j) -> PCWr=1 with NPCOp=10 in cycle 3; inst=0x34220005 (ori) -> ALUOp=011 and ExtOp=0 in EXEC_I.
- inst=0xFC000000 (illegal opcode) -> DECODE then FETCH; illegal=1 from that edge; a following legal add still executes; illegal remains 1.
- rst=1 asserted during MEM_WR of sw 0xAC220004 -> DMWr=0 that cycle; the state after the edge is FETCH; illegal=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, instruction
// fields, instruction classes and the ALU / next-PC select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } aluop_t;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BR  = 2'b01,
        NPC_JMP = 2'b10
    } npcop_t;

    typedef enum logic [2:0] {
        RTYPE,
        ORI,
        LW,
        SW,
        BEQ,
        J,
        ILL
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// plus the ALU operation an R-type instruction needs.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output aluop_t     rtype_alu
);

    always_comb begin
        iclass    = ILL;
        rtype_alu = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin iclass = RTYPE; rtype_alu = ALU_ADD; end
                    FN_SUB: begin iclass = RTYPE; rtype_alu = ALU_SUB; end
                    FN_AND: begin iclass = RTYPE; rtype_alu = ALU_AND; end
                    FN_OR:  begin iclass = RTYPE; rtype_alu = ALU_OR;  end
                    FN_SLT: begin iclass = RTYPE; rtype_alu = ALU_SLT; end
                    default: iclass = ILL;
                endcase
            end
            OP_ORI:  iclass = ORI;
            OP_LW:   iclass = LW;
            OP_SW:   iclass = SW;
            OP_BEQ:  iclass = BEQ;
            OP_J:    iclass = J;
            default: iclass = ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller for a small MIPS-like datapath: state register,
// sticky illegal-instruction flag and per-state control outputs.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zero,
    output logic        IRWr,
    output logic        PCWr,
    output logic [1:0]  NPCOp,
    output logic        RFWr,
    output logic        DMWr,
    output logic [2:0]  ALUOp,
    output logic        ALUSrcB,
    output logic        ExtOp,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        illegal,
    output logic [3:0]  state_o
);

    state_t  state;
    state_t  state_next;
    iclass_t iclass;
    aluop_t  rtype_alu;
    logic    unused_inst_bits;

    assign unused_inst_bits = ^inst[25:6];

    mc_decode u_decode (
        .opcode    (inst[31:26]),
        .funct     (inst[5:0]),
        .iclass    (iclass),
        .rtype_alu (rtype_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE && iclass == ILL)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (iclass)
                    RTYPE:   state_next = EXEC_R;
                    ORI:     state_next = EXEC_I;
                    LW, SW:  state_next = MEM_ADDR;
                    BEQ:     state_next = BRANCH;
                    J:       state_next = JUMP;
                    default: state_next = FETCH;
                endcase
            end
            EXEC_R, EXEC_I: state_next = WB_ALU;
            MEM_ADDR: state_next = (iclass == LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_next = MEM_WB;
            default:  state_next = FETCH;
        endcase
    end

    // Enables are gated by rst so a reset mid-instruction has no side effects
    // in the cycle it is asserted.
    always_comb begin
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        NPCOp    = NPC_PC4;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrcB  = 1'b0;
        ExtOp    = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        case (state)
            FETCH: begin
                IRWr  = 1'b1;
                PCWr  = 1'b1;
                NPCOp = NPC_PC4;
            end
            EXEC_R: begin
                ALUOp   = rtype_alu;
                ALUSrcB = 1'b0;
            end
            EXEC_I: begin
                ALUOp   = ALU_OR;
                ALUSrcB = 1'b1;
                ExtOp   = 1'b0;
            end
            WB_ALU: begin
                RFWr     = 1'b1;
                MemToReg = 1'b0;
                RegDst   = (iclass == RTYPE);
            end
            MEM_ADDR: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtOp   = 1'b1;
            end
            MEM_WB: begin
                RFWr     = 1'b1;
                MemToReg = 1'b1;
                RegDst   = 1'b0;
            end
            MEM_WR: DMWr = 1'b1;
            BRANCH: begin
                ALUOp   = ALU_SUB;
                ALUSrcB = 1'b0;
                NPCOp   = NPC_BR;
                PCWr    = zero;
            end
            JUMP: begin
                PCWr  = 1'b1;
                NPCOp = NPC_JMP;
            end
            default: ;
        endcase
        if (rst) begin
            IRWr = 1'b0;
            PCWr = 1'b0;
            RFWr = 1'b0;
            DMWr = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and
// compares state and packed controls against hand-computed vectors.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        zero;
    logic        IRWr, PCWr, RFWr, DMWr;
    logic [1:0]  NPCOp;
    logic [2:0]  ALUOp;
    logic        ALUSrcB, ExtOp, RegDst, MemToReg;
    logic        illegal;
    logic [3:0]  state_o;
    logic [12:0] got_ctl;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .zero     (zero),
        .IRWr     (IRWr),
        .PCWr     (PCWr),
        .NPCOp    (NPCOp),
        .RFWr     (RFWr),
        .DMWr     (DMWr),
        .ALUOp    (ALUOp),
        .ALUSrcB  (ALUSrcB),
        .ExtOp    (ExtOp),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .illegal  (illegal),
        .state_o  (state_o)
    );

    // {IRWr,PCWr,NPCOp[1:0],RFWr,DMWr,ALUOp[2:0],ALUSrcB,ExtOp,RegDst,MemToReg}
    assign got_ctl = {IRWr, PCWr, NPCOp, RFWr, DMWr, ALUOp, ALUSrcB, ExtOp, RegDst, MemToReg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input state_t st, input logic [12:0] c);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".ctl"}, 32'(got_ctl), 32'(c));
        chk({tag, ".excl"}, 32'((32'(IRWr) + 32'(RFWr) + 32'(DMWr)) <= 32'd1), 32'd1);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        inst = 32'h00221820;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc("rst_hold", FETCH, 13'h0000);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // add $3,$1,$2
        rst = 1'b0;
        #1;
        cyc("add_f", FETCH, 13'h1800);
        tick; cyc("add_d", DECODE, 13'h000);
        tick; cyc("add_x", EXEC_R, 13'h000);
        tick; cyc("add_wb", WB_ALU, 13'h102);
        tick; cyc("add_end", FETCH, 13'h1800);

        // lw
        inst = 32'h8C220004;
        tick; cyc("lw_d", DECODE, 13'h000);
        tick; cyc("lw_a", MEM_ADDR, 13'h00C);
        tick; cyc("lw_rd", MEM_RD, 13'h000);
        tick; cyc("lw_wb", MEM_WB, 13'h101);
        tick; cyc("lw_end", FETCH, 13'h1800);

        // beq taken
        inst = 32'h10220001;
        zero = 1'b1;
        tick; cyc("beq1_d", DECODE, 13'h000);
        tick; cyc("beq1_b", BRANCH, 13'hA10);
        tick; cyc("beq1_end", FETCH, 13'h1800);

        // beq not taken, then zero toggled inside BRANCH
        zero = 1'b0;
        tick; cyc("beq2_d", DECODE, 13'h000);
        tick; cyc("beq2_b", BRANCH, 13'h210);
        zero = 1'b1;
        #1 cyc("beq2_comb", BRANCH, 13'hA10);
        zero = 1'b0;
        #1;
        tick; cyc("beq2_end", FETCH, 13'h1800);

        // j
        inst = 32'h08000010;
        tick; cyc("j_d", DECODE, 13'h000);
        tick; cyc("j_j", JUMP, 13'hC00);
        tick; cyc("j_end", FETCH, 13'h1800);

        // ori
        inst = 32'h34220005;
        tick; cyc("ori_d", DECODE, 13'h000);
        tick; cyc("ori_x", EXEC_I, 13'h038);
        tick; cyc("ori_wb", WB_ALU, 13'h100);
        tick; cyc("ori_end", FETCH, 13'h1800);

        // illegal opcode
        inst = 32'hFC000000;
        tick; cyc("ill_d", DECODE, 13'h000);
        chk("ill_pre", 32'(illegal), 32'd0);
        tick; cyc("ill_f", FETCH, 13'h1800);
        chk("ill_set", 32'(illegal), 32'd1);

        inst = 32'h00221820;
        tick; cyc("add2_d", DECODE, 13'h000);
        tick; cyc("add2_x", EXEC_R, 13'h000);
        tick; cyc("add2_wb", WB_ALU, 13'h102);
        tick; cyc("add2_end", FETCH, 13'h1800);
        chk("ill_sticky", 32'(illegal), 32'd1);

        // sw, reset asserted in MEM_WR
        inst = 32'hAC220004;
        tick; cyc("sw_d", DECODE, 13'h000);
        tick; cyc("sw_a", MEM_ADDR, 13'h00C);
        tick; cyc("sw_wr", MEM_WR, 13'h080);
        rst = 1'b1;
        #1 cyc("sw_rst", MEM_WR, 13'h000);
        tick; cyc("sw_rst_f", FETCH, 13'h0000);
        chk("rst_clr_ill", 32'(illegal), 32'd0);
        rst = 1'b0;
        #1 cyc("rel_f", FETCH, 13'h1800);

        // R-type with unlisted funct (sll)
        inst = 32'h00000000;
        tick; cyc("fn_d", DECODE, 13'h000);
        chk("fn_pre", 32'(illegal), 32'd0);
        tick; cyc("fn_f", FETCH, 13'h1800);
        chk("fn_ill", 32'(illegal), 32'd1);

        // slt
        inst = 32'h0022182A;
        tick; cyc("slt_d", DECODE, 13'h000);
        tick; cyc("slt_x", EXEC_R, 13'h040);
        tick; cyc("slt_wb", WB_ALU, 13'h102);
        tick; cyc("slt_end", FETCH, 13'h1800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
